vita_tx_control_mc: RTL and testbench
=====================================

# vita_tx_control_mc

Multi-channel, parametrised successor to the single-channel VITA TX sequencer. It sits between the VITA TX deframer sample FIFO and the DSP TX chain, and releases NCHAN time-aligned samples per strobe once the packet's send time is reached. It enforces sequence and timing policy with a programmable late/too-early window. Status messages (ack and errors) go into a small internal FIFO, so back-to-back events are never lost.

## Interface
- BASE, 0: settings-bus base address.
- WIDTH, 32: sample width per channel.
- NCHAN, 1: channel count, 1..4.
- MSG_AW, 2: log2 depth of the message FIFO (4 entries).
- MAX_IDLE, 1000000: idle cycles before `run` drops outside a burst.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous soft clear; same effect as reset, except settings registers keep their values.
- set_stb, set_addr, set_data  in  1/8/32  settings bus.
- vita_time  in  64  current time.
- sample_fifo_i  in  85+NCHAN*WIDTH  bit fields:
  - [63:0] send_time
  - [79:64] seqnum
  - 80 eop
  - 81 eob
  - 82 sob
  - 83 send_at
  - 84 seqnum_err
  - [85+:NCHAN*WIDTH] samples, ch0 in the LSBs.
- sample_fifo_src_rdy_i  in  1.
- sample_fifo_dst_rdy_o  out  1.
- strobe  in  1  DSP sample request.
- sample  out  NCHAN*WIDTH  registered samples.
- run  out  1  DSP enable.
- msg_o  out  32  {seqnum, code}.
- msg_src_rdy_o  out  1.
- msg_dst_rdy_i  in  1.
- msg_overflow  out  1  sticky flag: a message was dropped.
- underrun_count  out  16  saturating count of underruns.
- packet_consumed  out  1  registered pulse, one per eop line consumed.

## Operation
- **Settings registers** (reset to 0):
  - BASE+3 policy: bit0 wait, bit1 next_packet, bit2 next_burst. Any write to BASE+3 also forces WAIT→IDLE.
  - BASE+4 max_lead[31:0].
  - BASE+5 chan_mask[NCHAN-1:0]. A masked channel outputs 0.
- **Time flags:**
  - now = (vita_time == send_time).
  - late = vita_time > send_time.
  - too_early = max_lead != 0 and send_time > vita_time + max_lead, computed with 64-bit unsigned arithmetic.
  - A late error requires late to be true on two consecutive cycles, with the head line valid and unconsumed on both.
- **Message codes:** EOB_ACK 1, UNDERRUN 2, SEQ_ERROR 4, LATE 8, UNDERRUN_MIDPKT 16, SEQ_ERROR_MIDBURST 32, TOO_EARLY 64. seqnum is taken from the head line at the time of the event.
- **State machine** (IDLE, RUN, CONT, ERROR, DONE, WAIT); no transition in IDLE unless src_rdy:
  - IDLE:
    - seqnum_err → ERROR, msg 4.
    - else ~send_at or now → RUN.
    - else qualified late → ERROR, msg 8.
    - else too_early → ERROR, msg 64.
  - RUN, on strobe:
    - ~src_rdy → ERROR, msg 16.
    - else eop&eob → DONE, msg 1.
    - else eop → CONT.
  - CONT:
    - strobe → msg 2; next state DONE if next_packet, else WAIT if wait, else ERROR.
    - else src_rdy & seqnum_err → ERROR, msg 32.
    - else src_rdy → RUN.
  - ERROR: consume lines. On src_rdy&eop: → IDLE if next_packet, or if next_burst&eob; else → WAIT if wait; else stay.
  - DONE → IDLE after 1 cycle.
  - WAIT: hold until a BASE+3 write.
- **Handshakes and datapath:**
  - sample_fifo_dst_rdy_o = (ERROR) | (RUN & strobe), combinational.
  - sample: zeroed while ~run; loaded on strobe & RUN & src_rdy, per-channel masked.
- **run:**
  - Set to 1 in RUN; the idle countdown is reloaded to MAX_IDLE every RUN cycle.
  - Cleared on the eob&eop consume.
  - Outside RUN, the countdown decrements and run clears when it reaches 0.
- **Message FIFO:**
  - One push per event.
  - Push while full drops the message and sets msg_overflow. The flag is cleared only by reset/clear.
  - Push and pop in the same cycle while full is legal and drops nothing.
- **underrun_count:** increments on msg 2 or msg 16; saturates at 0xFFFF.

## Timing
- Reset/clear values: state IDLE, run 0, sample 0, msg FIFO empty, msg_src_rdy_o 0, msg_overflow 0, underrun_count 0, packet_consumed 0.
- A message pushed on edge N is visible at msg_o, with msg_src_rdy_o high, after edge N (1-cycle latency).
- IDLE→RUN takes one edge. The first sample is consumed on the first strobe in RUN, and sample updates on the edge after that strobe.
- packet_consumed is high on the cycle after the eop line handshake.
- Reset mid-burst aborts immediately; no message is emitted.

## Test plan
- NCHAN=2, send_at=0, 3-line packet with eob, strobe every cycle → 3 samples out in order, msg {seq,1}, run falls the cycle after the last consume.
- Head line send_at, send_time=vita_time+10, max_lead=100 → sample output starts exactly at vita_time==send_time. Repeat with max_lead=5 → msg 64, line flushed under next_packet.
- send_time 5 ticks in the past → msg 8 after 2-cycle qualification. A packet late for only 1 cycle is not flagged.
- Burst without eob, then no data, then strobe → msg 2, underrun_count=1. With policy wait: state holds until a BASE+3 write, then IDLE.
- msg_dst_rdy_i=0, 5 errors → 4 queued, msg_overflow=1; draining returns the first 4 codes in order.
- chan_mask=01 → ch1 sample field is 0, ch0 passes; clear mid-RUN → run=0, sample=0 next cycle.

Source files
------------

// File: rtl/vita_tx_control_mc.sv
// Generic single-clock FIFO used for the status message queue.
// Latency: a word written on edge N is visible at rd_dat_o after edge N.
// Backpressure: wr_rdy_o drops only when full and no read is taken in the same cycle.
module vita_fifo #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          srst_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          wr_vld_i,
    output logic          wr_rdy_o,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_vld_o,
    input  logic          rd_rdy_i
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;

    assign rd_vld_o = (cnt_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign wr_rdy_o = (cnt_q != (AW+1)'(DEPTH)) | rd_rdy_i;
    assign push     = wr_vld_i & wr_rdy_o;
    assign pop      = rd_vld_o & rd_rdy_i;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// Multi-channel VITA TX sequencer: releases NCHAN samples per strobe once send time is reached.
// Latency: IDLE->RUN one edge; sample updates the edge after a strobe; messages visible 1 cycle after the event.
// Backpressure: pulls lines only in RUN on strobe or while flushing in ERROR; full message queue drops and flags.
module vita_tx_control_mc #(
    parameter int BASE     = 0,
    parameter int WIDTH    = 32,
    parameter int NCHAN    = 1,
    parameter int MSG_AW   = 2,
    parameter int MAX_IDLE = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         set_stb,
    input  logic [7:0]                   set_addr,
    input  logic [31:0]                  set_data,
    input  logic [63:0]                  vita_time,
    input  logic [85+NCHAN*WIDTH-1:0]    sample_fifo_i,
    input  logic                         sample_fifo_src_rdy_i,
    output logic                         sample_fifo_dst_rdy_o,
    input  logic                         strobe,
    output logic [NCHAN*WIDTH-1:0]       sample,
    output logic                         run,
    output logic [31:0]                  msg_o,
    output logic                         msg_src_rdy_o,
    input  logic                         msg_dst_rdy_i,
    output logic                         msg_overflow,
    output logic [15:0]                  underrun_count,
    output logic                         packet_consumed
);
    localparam int SW = NCHAN * WIDTH;
    localparam int CW = $clog2(MAX_IDLE + 1);

    localparam logic [7:0] A_POLICY   = 8'(BASE + 3);
    localparam logic [7:0] A_MAX_LEAD = 8'(BASE + 4);
    localparam logic [7:0] A_MASK     = 8'(BASE + 5);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_CONT  = 3'd2;
    localparam logic [2:0] S_ERROR = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    localparam logic [15:0] C_EOB_ACK   = 16'd1;
    localparam logic [15:0] C_UNDERRUN  = 16'd2;
    localparam logic [15:0] C_SEQ_ERR   = 16'd4;
    localparam logic [15:0] C_LATE      = 16'd8;
    localparam logic [15:0] C_UNDER_MID = 16'd16;
    localparam logic [15:0] C_SEQ_MIDB  = 16'd32;
    localparam logic [15:0] C_TOO_EARLY = 16'd64;

    logic srst;
    assign srst = reset | clear;

    logic [2:0]       policy_q;
    logic [31:0]      max_lead_q;
    logic [NCHAN-1:0] chan_mask_q;
    logic             policy_wr;

    assign policy_wr = set_stb & (set_addr == A_POLICY);

    always_ff @(posedge clk) begin
        if (reset) begin
            policy_q    <= '0;
            max_lead_q  <= '0;
            chan_mask_q <= '0;
        end else if (set_stb) begin
            if (set_addr == A_POLICY)   policy_q    <= set_data[2:0];
            if (set_addr == A_MAX_LEAD) max_lead_q  <= set_data;
            if (set_addr == A_MASK)     chan_mask_q <= set_data[NCHAN-1:0];
        end
    end

    logic          pol_wait, pol_next_pkt, pol_next_burst;
    assign pol_wait       = policy_q[0];
    assign pol_next_pkt   = policy_q[1];
    assign pol_next_burst = policy_q[2];

    logic [63:0]   send_time;
    logic [15:0]   seqnum;
    logic          eop, eob, send_at, seq_err;
    logic [SW-1:0] fifo_smp;
    logic          unused_sob;

    assign send_time  = sample_fifo_i[63:0];
    assign seqnum     = sample_fifo_i[79:64];
    assign eop        = sample_fifo_i[80];
    assign eob        = sample_fifo_i[81];
    assign unused_sob = sample_fifo_i[82];
    assign send_at    = sample_fifo_i[83];
    assign seq_err    = sample_fifo_i[84];
    assign fifo_smp   = sample_fifo_i[85 +: SW];

    logic [63:0] lead_limit;
    logic        now, late, too_early, late_q, late_qual;
    logic        src_rdy, consume;

    assign src_rdy    = sample_fifo_src_rdy_i;
    assign lead_limit = vita_time + {32'd0, max_lead_q};
    assign now        = (vita_time == send_time);
    assign late       = (vita_time > send_time);
    assign too_early  = (max_lead_q != '0) & (send_time > lead_limit);
    // Lateness must persist on the same unconsumed head line for two cycles.
    assign late_qual  = src_rdy & late & late_q;

    logic [2:0]  state_q, state_d;
    logic        ev_vld;
    logic [15:0] ev_code;

    assign sample_fifo_dst_rdy_o = (state_q == S_ERROR) | ((state_q == S_RUN) & strobe);
    assign consume               = src_rdy & sample_fifo_dst_rdy_o;

    always_comb begin
        state_d = state_q;
        ev_vld  = 1'b0;
        ev_code = '0;
        case (state_q)
            S_IDLE: if (src_rdy) begin
                if (seq_err) begin
                    state_d = S_ERROR; ev_vld = 1'b1; ev_code = C_SEQ_ERR;
                end else if (!send_at || now) begin
                    state_d = S_RUN;
                end else if (late_qual) begin
                    state_d = S_ERROR; ev_vld = 1'b1; ev_code = C_LATE;
                end else if (too_early) begin
                    state_d = S_ERROR; ev_vld = 1'b1; ev_code = C_TOO_EARLY;
                end
            end
            S_RUN: if (strobe) begin
                if (!src_rdy) begin
                    state_d = S_ERROR; ev_vld = 1'b1; ev_code = C_UNDER_MID;
                end else if (eop && eob) begin
                    state_d = S_DONE; ev_vld = 1'b1; ev_code = C_EOB_ACK;
                end else if (eop) begin
                    state_d = S_CONT;
                end
            end
            S_CONT: begin
                if (strobe) begin
                    ev_vld  = 1'b1;
                    ev_code = C_UNDERRUN;
                    state_d = pol_next_pkt ? S_DONE : (pol_wait ? S_WAIT : S_ERROR);
                end else if (src_rdy && seq_err) begin
                    state_d = S_ERROR; ev_vld = 1'b1; ev_code = C_SEQ_MIDB;
                end else if (src_rdy) begin
                    state_d = S_RUN;
                end
            end
            S_ERROR: if (src_rdy && eop) begin
                if (pol_next_pkt || (pol_next_burst && eob)) state_d = S_IDLE;
                else if (pol_wait)                            state_d = S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            S_WAIT:  if (policy_wr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic [CW-1:0] idle_cnt_q;
    logic          run_q;
    logic [SW-1:0] sample_q, smp_masked;
    logic          pkt_q, load;
    logic [15:0]   under_q;

    always_comb begin
        smp_masked = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (chan_mask_q[c]) smp_masked[c*WIDTH +: WIDTH] = fifo_smp[c*WIDTH +: WIDTH];
        end
    end

    assign load = strobe & (state_q == S_RUN) & src_rdy;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= S_IDLE;
            late_q     <= 1'b0;
            run_q      <= 1'b0;
            idle_cnt_q <= '0;
            sample_q   <= '0;
            pkt_q      <= 1'b0;
            under_q    <= '0;
        end else begin
            state_q <= state_d;
            late_q  <= src_rdy & late & ~consume;
            pkt_q   <= consume & eop;

            if (state_q == S_RUN)               idle_cnt_q <= CW'(MAX_IDLE);
            else if (run_q && idle_cnt_q != '0) idle_cnt_q <= idle_cnt_q - 1'b1;

            // The last line of a burst ends run at once; otherwise it times out after leaving RUN.
            if (consume && eop && eob)                                run_q <= 1'b0;
            else if (state_d == S_RUN)                                run_q <= 1'b1;
            else if (state_q != S_RUN && idle_cnt_q <= CW'(1))        run_q <= 1'b0;

            if (load)        sample_q <= smp_masked;
            else if (!run_q) sample_q <= '0;

            if (ev_vld && (ev_code == C_UNDERRUN || ev_code == C_UNDER_MID) && under_q != 16'hFFFF)
                under_q <= under_q + 16'd1;
        end
    end

    logic msg_in_rdy, ovf_q;

    vita_fifo #(.DW(32), .AW(MSG_AW)) u_msg_fifo (
        .clk      (clk),
        .srst_i   (srst),
        .wr_dat_i ({seqnum, ev_code}),
        .wr_vld_i (ev_vld),
        .wr_rdy_o (msg_in_rdy),
        .rd_dat_o (msg_o),
        .rd_vld_o (msg_src_rdy_o),
        .rd_rdy_i (msg_dst_rdy_i)
    );

    always_ff @(posedge clk) begin
        if (srst)                     ovf_q <= 1'b0;
        else if (ev_vld && !msg_in_rdy) ovf_q <= 1'b1;
    end

    assign sample          = sample_q;
    assign run             = run_q;
    assign msg_overflow    = ovf_q;
    assign underrun_count  = under_q;
    assign packet_consumed = pkt_q;
endmodule

// File: tb/tb_vita_tx_control_mc.sv
// Randomized scenario bench for vita_tx_control_mc with a queue-based line source and message scoreboard.
module tb_vita_tx_control_mc;
    localparam int W = 16, N = 2, LW = 85 + N*W, MAX_IDLE = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clear, set_stb, strobe, msg_dst_rdy_i;
    logic [7:0]    set_addr;
    logic [31:0]   set_data, msg_o;
    logic [63:0]   vita_time;
    logic [LW-1:0] sample_fifo_i;
    logic          sample_fifo_src_rdy_i, sample_fifo_dst_rdy_o;
    logic [N*W-1:0] sample;
    logic          run, msg_src_rdy_o, msg_overflow, packet_consumed;
    logic [15:0]   underrun_count;

    vita_tx_control_mc #(.BASE(0), .WIDTH(W), .NCHAN(N), .MSG_AW(2), .MAX_IDLE(MAX_IDLE)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .vita_time(vita_time),
        .sample_fifo_i(sample_fifo_i), .sample_fifo_src_rdy_i(sample_fifo_src_rdy_i),
        .sample_fifo_dst_rdy_o(sample_fifo_dst_rdy_o),
        .strobe(strobe), .sample(sample), .run(run),
        .msg_o(msg_o), .msg_src_rdy_o(msg_src_rdy_o), .msg_dst_rdy_i(msg_dst_rdy_i),
        .msg_overflow(msg_overflow), .underrun_count(underrun_count),
        .packet_consumed(packet_consumed)
    );

    int n_chk = 0, n_err = 0;
    logic [LW-1:0] lines[$];
    logic [31:0]   exp_msg[$];
    logic [63:0]   vt = 64'd1000;
    bit            vt_auto = 1'b1, data_chk = 1'b0;
    logic [N-1:0]  mask_m = '0;
    logic          last_c;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk(input logic [15:0] seq, input logic [63:0] t,
                                         input logic eop, input logic eob,
                                         input logic sat, input logic serr);
        logic [LW-1:0] l = '0;
        l[63:0]    = t;
        l[79:64]   = seq;
        l[80]      = eop;
        l[81]      = eob;
        l[83]      = sat;
        l[84]      = serr;
        l[85 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [N*W-1:0] mask_smp(input logic [LW-1:0] l);
        logic [N*W-1:0] r = '0;
        for (int c = 0; c < N; c++)
            if (mask_m[c]) r[c*W +: W] = l[85 + c*W +: W];
        return r;
    endfunction

    // One clock: present the source head, score messages, take the handshake, check registered outputs.
    task automatic cyc();
        logic [LW-1:0] hd;
        logic c;
        sample_fifo_src_rdy_i = (lines.size() > 0);
        sample_fifo_i         = (lines.size() > 0) ? lines[0] : '0;
        vita_time             = vt;
        #1;
        if (msg_src_rdy_o && msg_dst_rdy_i) begin
            if (exp_msg.size() == 0) chk("msg_unexpected", msg_src_rdy_o, 0);
            else                     chk("msg", msg_o, exp_msg.pop_front());
        end
        c  = sample_fifo_src_rdy_i & sample_fifo_dst_rdy_o;
        hd = sample_fifo_i;
        @(posedge clk);
        if (c) void'(lines.pop_front());
        if (vt_auto) vt = vt + 64'd1;
        @(negedge clk);
        last_c = c;
        chk("pkt_consumed", packet_consumed, c & hd[80]);
        if (c && data_chk) chk("sample", sample, mask_smp(hd));
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        cyc();
        set_stb = 1'b0;
    endtask

    task automatic drain_lines(input int bound);
        for (int i = 0; i < bound && lines.size() > 0; i++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic [63:0] t0, tv;
        bit hit;
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        strobe = 1'b0; msg_dst_rdy_i = 1'b1; vita_time = vt;
        sample_fifo_i = '0; sample_fifo_src_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_run", run, 0);
        chk("rst_sample", sample, 0);
        chk("rst_msg_vld", msg_src_rdy_o, 0);
        chk("rst_ovf", msg_overflow, 0);
        chk("rst_under", underrun_count, 0);
        chk("rst_pkt", packet_consumed, 0);
        chk("rst_dst_rdy", sample_fifo_dst_rdy_o, 0);
        reset = 1'b0;

        // Immediate 3-line burst, both channels enabled.
        wr(8'd3, 32'd2); wr(8'd5, 32'd3); mask_m = 2'b11; data_chk = 1'b1; strobe = 1'b1;
        s = 16'($urandom);
        for (int i = 0; i < 3; i++) lines.push_back(mk(s + 16'(i), 64'd0, i == 2, i == 2, 1'b0, 1'b0));
        exp_msg.push_back({s + 16'd2, 16'd1});
        cyc();
        chk("s1_run_up", run, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s1_take", last_c, 1);
        end
        chk("s1_run_fall", run, 0);
        strobe = 1'b0;
        repeat (4) cyc();
        chk("s1_idle_zero", sample, 0);

        // Timed line inside the lead window starts exactly at send_time.
        wr(8'd4, 32'd100); strobe = 1'b1;
        s = 16'($urandom); t0 = vt + 64'd10;
        lines.push_back(mk(s, t0, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_msg.push_back({s, 16'd1});
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            tv = vt;
            cyc();
            if (run) begin
                hit = 1'b1;
                chk("s2_start_time", tv, t0);
            end
        end
        if (!hit) chk("s2_run_timeout", run, 1);
        cyc();
        strobe = 1'b0;
        repeat (3) cyc();

        // Same offset with a narrow lead window: too early, flushed.
        wr(8'd4, 32'd5); data_chk = 1'b0;
        s = 16'($urandom);
        lines.push_back(mk(s, vt + 64'd10, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_msg.push_back({s, 16'd64});
        drain_lines(10);
        chk("s2b_flush", lines.size(), 0);
        chk("s2b_run", run, 0);
        repeat (3) cyc();

        // Late line: flagged only on the second late cycle.
        wr(8'd4, 32'd0);
        s = 16'($urandom);
        lines.push_back(mk(s, vt - 64'd5, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_msg.push_back({s, 16'd8});
        cyc();
        chk("s3_late_q1", msg_src_rdy_o, 0);
        cyc();
        chk("s3_late_q2", msg_src_rdy_o, 1);
        drain_lines(10);
        chk("s3_flush", lines.size(), 0);
        repeat (3) cyc();

        // Late for a single cycle then on time: not flagged.
        vt_auto = 1'b0; data_chk = 1'b1; strobe = 1'b1;
        s = 16'($urandom); t0 = vt + 64'd50;
        lines.push_back(mk(s, t0, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_msg.push_back({s, 16'd1});
        vt = t0 + 64'd1; cyc();
        vt = t0;         cyc();
        chk("s3b_run", run, 1);
        cyc();
        vt_auto = 1'b1; vt = t0 + 64'd2; strobe = 1'b0;
        repeat (3) cyc();

        // Burst without eob then no data: underrun, hold in WAIT, run times out.
        wr(8'd3, 32'd1); strobe = 1'b1;
        s = 16'($urandom);
        lines.push_back(mk(s, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        lines.push_back(mk(s + 16'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_msg.push_back({16'd0, 16'd2});
        repeat (4) cyc();
        strobe = 1'b0;
        s = 16'($urandom);
        lines.push_back(mk(s, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        repeat (5) cyc();
        chk("s4_hold", lines.size(), 1);
        chk("s4_under", underrun_count, 1);
        chk("s4_run_hold", run, 1);
        repeat (MAX_IDLE) cyc();
        chk("s4_run_drop", run, 0);
        chk("s4_still_hold", lines.size(), 1);
        wr(8'd3, 32'd2); strobe = 1'b1;
        exp_msg.push_back({s, 16'd1});
        drain_lines(10);
        chk("s4_resume", lines.size(), 0);
        strobe = 1'b0;
        repeat (3) cyc();

        // Five errors with the message sink stalled: four kept, fifth dropped.
        msg_dst_rdy_i = 1'b0; data_chk = 1'b0;
        wr(8'd4, 32'd5);
        s = 16'($urandom);
        lines.push_back(mk(s, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        exp_msg.push_back({s, 16'd4});
        s = 16'($urandom);
        lines.push_back(mk(s, vt + 64'd1000, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_msg.push_back({s, 16'd64});
        s = 16'($urandom);
        lines.push_back(mk(s, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        exp_msg.push_back({s, 16'd4});
        s = 16'($urandom);
        lines.push_back(mk(s, 64'd10, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_msg.push_back({s, 16'd8});
        lines.push_back(mk(16'($urandom), 64'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        drain_lines(40);
        chk("s5_flush", lines.size(), 0);
        repeat (2) cyc();
        chk("s5_ovf", msg_overflow, 1);
        chk("s5_vld", msg_src_rdy_o, 1);
        msg_dst_rdy_i = 1'b1;
        repeat (6) cyc();
        chk("s5_empty", msg_src_rdy_o, 0);
        chk("s5_ovf_sticky", msg_overflow, 1);

        // Channel mask with random strobe pacing.
        wr(8'd4, 32'd0); wr(8'd5, 32'd1); mask_m = 2'b01; data_chk = 1'b1;
        s = 16'($urandom);
        for (int i = 0; i < 3; i++) lines.push_back(mk(s + 16'(i), 64'd0, i == 2, i == 2, 1'b0, 1'b0));
        exp_msg.push_back({s + 16'd2, 16'd1});
        for (int i = 0; i < 60 && lines.size() > 0; i++) begin
            strobe = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("s6_done", lines.size(), 0);
        strobe = 1'b0;
        repeat (3) cyc();

        // Soft clear mid-RUN aborts silently and keeps settings.
        s = 16'($urandom);
        for (int i = 0; i < 4; i++) lines.push_back(mk(s + 16'(i), 64'd0, i == 3, i == 3, 1'b0, 1'b0));
        exp_msg.push_back({s + 16'd3, 16'd1});
        strobe = 1'b1;
        repeat (3) cyc();
        chk("clr_pre_run", run, 1);
        strobe = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_run", run, 0);
        chk("clr_sample", sample, 0);
        chk("clr_under", underrun_count, 0);
        chk("clr_ovf", msg_overflow, 0);
        strobe = 1'b1;
        drain_lines(20);
        chk("clr_resume", lines.size(), 0);
        strobe = 1'b0;
        repeat (4) cyc();
        chk("msg_leftover", exp_msg.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
